// File: rtl/pe_result_streamer_pkg.sv
// Shared types for the PE result streamer: framing FSM states, UART handshake
// states and the byte-type tag carried through a send.
package pe_pkg;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD,
        ST_CAP,
        ST_SEND,
        ST_CSUM,
        ST_FIN
    } state_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_REQ,
        HS_ACK,
        HS_WAIT
    } hs_state_e;

    typedef enum logic [1:0] {
        BT_HDR,
        BT_DATA,
        BT_CSUM
    } byte_type_e;

endpackage

// File: rtl/pe_result_streamer_tx_handshake.sv
// One byte exchange with the UART tx: wait for idle, pulse tx_start, wait for
// tx_busy to rise (bounded by ACK_TIMEOUT) and then fall.
module tx_handshake
    import pe_pkg::*;
#(
    parameter int ACK_TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic send_i,
    input  logic tx_busy_i,
    output logic tx_start_o,
    output logic sent_o,
    output logic timeout_o
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    hs_state_e       hs_q, hs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tx_start_q, tx_start_d;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        hs_d       = hs_q;
        cnt_d      = cnt_q;
        tx_start_d = 1'b0;
        sent_o     = 1'b0;
        timeout_o  = 1'b0;
        case (hs_q)
            HS_IDLE, HS_REQ: begin
                if (send_i || hs_q == HS_REQ) begin
                    if (!tx_busy_i) begin
                        tx_start_d = 1'b1;
                        cnt_d      = '0;
                        hs_d       = HS_ACK;
                    end else begin
                        hs_d = HS_REQ;
                    end
                end
            end
            HS_ACK: begin
                // Abort on the edge that makes the count visible as ACK_TIMEOUT.
                if (tx_busy_i) begin
                    hs_d = HS_WAIT;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    timeout_o = 1'b1;
                    hs_d      = HS_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HS_WAIT: begin
                if (!tx_busy_i) begin
                    sent_o = 1'b1;
                    hs_d   = HS_IDLE;
                end
            end
            default: hs_d = HS_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q       <= HS_IDLE;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
        end else begin
            hs_q       <= hs_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
        end
    end

    assign tx_start_o = tx_start_q;

endmodule

// File: rtl/pe_result_streamer.sv
// Streams memC out over the UART as HEADER, DEPTH data bytes, XOR checksum.
// Framing and addressing live here; the byte handshake is in tx_handshake.
module pe_result_streamer
    import pe_pkg::*;
#(
    parameter int         DEPTH       = 16,
    parameter int         AW          = 4,
    parameter logic [7:0] HEADER      = DEFAULT_HEADER,
    parameter int         ACK_TIMEOUT = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_busy,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [7:0]    checksum
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    byte_type_e    btype_q, btype_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [7:0]    checksum_q, checksum_d;
    logic          err_q, err_d;
    logic          rd_en_q, rd_en_d;
    logic          done_q, done_d;
    logic          busy_q;
    logic          send, sent, timeout;

    always_comb begin
        state_d    = state_q;
        btype_d    = btype_q;
        addr_d     = addr_q;
        tx_data_d  = tx_data_q;
        checksum_d = checksum_q;
        err_d      = err_q;
        rd_en_d    = 1'b0;
        done_d     = 1'b0;
        send       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_HDR;
                    checksum_d = '0;
                    addr_d     = '0;
                    err_d      = 1'b0;
                end
            end
            ST_HDR: begin
                tx_data_d = HEADER;
                btype_d   = BT_HDR;
                send      = 1'b1;
                state_d   = ST_SEND;
            end
            ST_RD:  state_d = ST_CAP;
            ST_CAP: begin
                tx_data_d  = mem_rdata;
                checksum_d = checksum_q ^ mem_rdata;
                btype_d    = BT_DATA;
                send       = 1'b1;
                state_d    = ST_SEND;
            end
            ST_CSUM: begin
                tx_data_d = checksum_q;
                btype_d   = BT_CSUM;
                send      = 1'b1;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (sent) begin
                    // The read strobe is registered on the edge that enters RD.
                    case (btype_q)
                        BT_HDR: begin
                            rd_en_d = 1'b1;
                            state_d = ST_RD;
                        end
                        BT_DATA: begin
                            if (addr_q == LAST_ADDR) begin
                                state_d = ST_CSUM;
                            end else begin
                                addr_d  = addr_q + 1'b1;
                                rd_en_d = 1'b1;
                                state_d = ST_RD;
                            end
                        end
                        default: begin
                            done_d  = 1'b1;
                            state_d = ST_FIN;
                        end
                    endcase
                end
            end
            ST_FIN: begin
                addr_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            btype_q    <= BT_HDR;
            addr_q     <= '0;
            tx_data_q  <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
            rd_en_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            btype_q    <= btype_d;
            addr_q     <= addr_d;
            tx_data_q  <= tx_data_d;
            checksum_q <= checksum_d;
            err_q      <= err_d;
            rd_en_q    <= rd_en_d;
            done_q     <= done_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    tx_handshake #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_tx_handshake (
        .clk       (clk),
        .rst       (rst),
        .send_i    (send),
        .tx_busy_i (tx_busy),
        .tx_start_o(tx_start),
        .sent_o    (sent),
        .timeout_o (timeout)
    );

    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_pe_result_streamer.sv
// Scoreboard bench: expected bytes are queued with each frame request and a
// negedge monitor pops and compares them on every tx_start.
module tb_pe_result_streamer;

    localparam int ATO = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // DEPTH=4 instance and its memory/UART models
    logic       start4 = 1'b0;
    logic       mem_rd_en4;
    logic [1:0] mem_addr4;
    logic [7:0] mem_rdata4 = 8'h00;
    logic [7:0] tx_data4;
    logic       tx_start4;
    logic       tx_busy4;
    logic       busy4, done4, err4;
    logic [7:0] checksum4;
    logic [7:0] mem4 [4];
    logic       uart_dead4 = 1'b0;
    logic       force_busy4 = 1'b0;
    int         busy_cnt4;

    pe_result_streamer #(.DEPTH(4), .AW(2), .HEADER(8'hA5), .ACK_TIMEOUT(ATO)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .mem_rd_en(mem_rd_en4), .mem_addr(mem_addr4), .mem_rdata(mem_rdata4),
        .tx_data(tx_data4), .tx_start(tx_start4), .tx_busy(tx_busy4),
        .busy(busy4), .done(done4), .err(err4), .checksum(checksum4)
    );

    always @(posedge clk) if (mem_rd_en4) mem_rdata4 <= mem4[mem_addr4];

    always @(posedge clk or posedge rst) begin
        if (rst)                           busy_cnt4 <= 0;
        else if (tx_start4 && !uart_dead4) busy_cnt4 <= 10;
        else if (busy_cnt4 != 0)           busy_cnt4 <= busy_cnt4 - 1;
    end
    assign tx_busy4 = force_busy4 || (busy_cnt4 != 0);

    // DEPTH=1 instance
    logic       start1 = 1'b0;
    logic       mem_rd_en1;
    logic [0:0] mem_addr1;
    logic [7:0] mem_rdata1 = 8'h00;
    logic [7:0] tx_data1;
    logic       tx_start1;
    logic       tx_busy1;
    logic       busy1, done1, err1;
    logic [7:0] checksum1;
    int         busy_cnt1;

    pe_result_streamer #(.DEPTH(1), .AW(1), .HEADER(8'hA5), .ACK_TIMEOUT(ATO)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1),
        .tx_data(tx_data1), .tx_start(tx_start1), .tx_busy(tx_busy1),
        .busy(busy1), .done(done1), .err(err1), .checksum(checksum1)
    );

    always @(posedge clk) if (mem_rd_en1) mem_rdata1 <= 8'hFF;

    always @(posedge clk or posedge rst) begin
        if (rst)                 busy_cnt1 <= 0;
        else if (tx_start1)      busy_cnt1 <= 10;
        else if (busy_cnt1 != 0) busy_cnt1 <= busy_cnt1 - 1;
    end
    assign tx_busy1 = (busy_cnt1 != 0);

    // Scoreboards and monitors
    logic [7:0] exp4[$];
    logic [7:0] exp1[$];
    int   bytes4 = 0, done4_cnt = 0, bytes1 = 0, done1_cnt = 0;
    logic prev_start4 = 1'b0, prev_start1 = 1'b0;
    logic addr1_bad = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start4) begin
                bytes4++;
                check("dut4 tx_start while tx_busy", tx_busy4, 0);
                check("dut4 tx_start back-to-back", prev_start4, 0);
                if (exp4.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut4 unexpected byte: got %0h expected none", tx_data4);
                end else begin
                    check("dut4 byte", tx_data4, exp4.pop_front());
                end
            end
            if (done4) done4_cnt++;
            prev_start4 = tx_start4;
        end else begin
            prev_start4 = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start1) begin
                bytes1++;
                check("dut1 tx_start back-to-back", prev_start1, 0);
                if (exp1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut1 unexpected byte: got %0h expected none", tx_data1);
                end else begin
                    check("dut1 byte", tx_data1, exp1.pop_front());
                end
            end
            if (done1) done1_cnt++;
            if (mem_addr1 != 1'b0) addr1_bad = 1'b1;
            prev_start1 = tx_start1;
        end else begin
            prev_start1 = 1'b0;
        end
    end

    task automatic push_frame4();
        exp4.push_back(8'hA5);
        exp4.push_back(8'h01);
        exp4.push_back(8'h02);
        exp4.push_back(8'h04);
        exp4.push_back(8'h08);
        exp4.push_back(8'h0F);
    endtask

    task automatic pulse_start4();
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
    endtask

    task automatic wait_done4(input string name);
        int d0 = done4_cnt;
        int n  = 0;
        while (done4_cnt == d0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, done4_cnt - d0, 1);
    endtask

    initial begin
        int b0, d0, n;
        mem4[0] = 8'h01; mem4[1] = 8'h02; mem4[2] = 8'h04; mem4[3] = 8'h08;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", busy4, 0);
        check("reset tx_start", tx_start4, 0);
        check("reset err/done", {err4, done4, mem_rd_en4}, 0);
        check("reset tx_data/checksum", {tx_data4, checksum4}, 0);

        // Normal frame, also checking busy/tx_start latency from start
        push_frame4();
        b0 = bytes4;
        pulse_start4();
        check("t1 busy after start", busy4, 1);
        check("t1 no tx_start yet", tx_start4, 0);
        @(negedge clk);
        check("t1 header tx_start", tx_start4, 1);
        wait_done4("t1 done count");
        repeat (5) @(negedge clk);
        check("t1 bytes", bytes4 - b0, 6);
        check("t1 checksum", checksum4, 8'h0F);
        check("t1 err", err4, 0);
        check("t1 busy after frame", busy4, 0);
        check("t1 queue empty", exp4.size(), 0);

        // Second start mid-frame is ignored
        push_frame4();
        b0 = bytes4;
        d0 = done4_cnt;
        pulse_start4();
        repeat (30) @(negedge clk);
        pulse_start4();
        wait_done4("t2 done count");
        repeat (60) @(negedge clk);
        check("t2 bytes", bytes4 - b0, 6);
        check("t2 single done", done4_cnt - d0, 1);
        check("t2 checksum", checksum4, 8'h0F);

        // UART busy when start arrives: header waits for it to fall
        force_busy4 = 1'b1;
        push_frame4();
        b0 = bytes4;
        pulse_start4();
        repeat (20) @(negedge clk);
        check("t3 no tx_start while busy", bytes4 - b0, 0);
        force_busy4 = 1'b0;
        wait_done4("t3 done count");
        check("t3 bytes", bytes4 - b0, 6);

        // UART never acknowledges: err after ACK_TIMEOUT cycles, no done
        uart_dead4 = 1'b1;
        exp4.push_back(8'hA5);
        d0 = done4_cnt;
        pulse_start4();
        n = 0;
        while (!tx_start4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t4 header issued", tx_start4, 1);
        n = 0;
        while (!err4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4 err latency", n, ATO);
        check("t4 idle after timeout", busy4, 0);
        repeat (5) @(negedge clk);
        check("t4 no done", done4_cnt - d0, 0);
        check("t4 err sticky", err4, 1);
        uart_dead4 = 1'b0;
        push_frame4();
        pulse_start4();
        check("t4 err cleared by start", err4, 0);
        wait_done4("t4 recovery done");
        check("t4 recovery checksum", checksum4, 8'h0F);

        // Asynchronous reset after the second data byte
        push_frame4();
        b0 = bytes4;
        pulse_start4();
        n = 0;
        while (bytes4 < b0 + 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t5 three bytes sent", bytes4 - b0, 3);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5 rst busy", busy4, 0);
        check("t5 rst tx_data", tx_data4, 0);
        check("t5 rst checksum", checksum4, 0);
        check("t5 rst mem_addr", mem_addr4, 0);
        check("t5 rst flags", {tx_start4, mem_rd_en4, done4, err4}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp4.delete();
        b0 = bytes4;
        repeat (60) @(negedge clk);
        check("t5 no tx_start after reset", bytes4 - b0, 0);
        push_frame4();
        pulse_start4();
        wait_done4("t5 refill done");
        check("t5 refill bytes", bytes4 - b0, 6);
        check("t5 queue empty", exp4.size(), 0);

        // DEPTH=1 frame
        exp1.push_back(8'hA5);
        exp1.push_back(8'hFF);
        exp1.push_back(8'hFF);
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        n = 0;
        while (done1_cnt == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t6 done count", done1_cnt, 1);
        check("t6 bytes", bytes1, 3);
        check("t6 checksum", checksum1, 8'hFF);
        check("t6 mem_addr stays 0", addr1_bad, 0);
        check("t6 queue empty", exp1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_result_streamer.md
# pe_result_streamer

Sequencer that streams the PE result memory (memC, 8-bit words) out through the UART transmitter. A `start` pulse makes it emit a fixed frame: a header byte, then every memC word in ascending address order, then an XOR checksum. It sits between the memory block and the UART tx in the FPGA top. It owns the tx handshake (`tx_data`/`tx_start`/`tx_busy`) and the memC read port.

## Interface
Parameters:
- `DEPTH`, 16: number of memC words per frame (≥1).
- `AW`, 4: address width, ≥ clog2(DEPTH).
- `HEADER`, 8'hA5: first byte of each frame.
- `ACK_TIMEOUT`, 32: maximum cycles to wait for `tx_busy` to rise after `tx_start`.

Ports:
- `clk` in 1: single clock for all state.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to send one frame; ignored unless in IDLE.
- `mem_rd_en` out 1: memC read strobe.
- `mem_addr` out AW: memC read address.
- `mem_rdata` in 8: memC data, valid exactly 1 cycle after `mem_rd_en`.
- `tx_data` out 8: byte presented to the UART tx; held stable from `tx_start` until `tx_busy` falls.
- `tx_start` out 1: one-cycle send pulse.
- `tx_busy` in 1: high while the UART is shifting a byte.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the checksum byte completes.
- `err` out 1: sticky ack-timeout flag; cleared by the next accepted `start`.
- `checksum` out 8: running XOR of the memC bytes sent; holds its final value after `done`.

## Operation
States are IDLE, HDR, RD, CAP, TXREQ, TXACK, TXWAIT, CSUM, FIN.
- **IDLE**: `start`=1 → HDR; clear `checksum`, `mem_addr`, `err`.
- **HDR**: load `tx_data`=HEADER → TXREQ. Byte type = header.
- **RD**: assert `mem_rd_en` for 1 cycle at `mem_addr` → CAP.
- **CAP**: latch `mem_rdata` into `tx_data`; `checksum ^= mem_rdata` → TXREQ. Byte type = data.
- **CSUM**: `tx_data`=`checksum` → TXREQ. Byte type = checksum.
- **TXREQ**: if `tx_busy`=0, pulse `tx_start` → TXACK; otherwise stay.
- **TXACK**: `tx_busy`=1 → TXWAIT. If the timeout counter reaches ACK_TIMEOUT with `tx_busy` still 0: set `err` and go to IDLE (frame aborted, no `done`).
- **TXWAIT**: `tx_busy`=0 → next step, chosen by byte type:
  - header → RD;
  - data and `mem_addr`≠DEPTH-1 → increment `mem_addr`, go to RD;
  - data and `mem_addr`=DEPTH-1 → go to CSUM, leave `mem_addr` unchanged;
  - checksum → FIN.
- **FIN**: pulse `done` → IDLE; `mem_addr` returns to 0.
- `checksum` covers data bytes only, never the header.
- `mem_addr` never exceeds DEPTH-1 and never wraps during a frame.

## Timing
- Reset values: state IDLE; `mem_rd_en`=0, `mem_addr`=0, `tx_data`=0, `tx_start`=0, `busy`=0, `done`=0, `err`=0, `checksum`=0. Reset applies asynchronously at any point, including mid-frame; after release no `tx_start` is issued until a new `start` arrives.
- `start` sampled at edge N → `busy`=1 from N+1. Earliest `tx_start` (header) is at N+2 when `tx_busy`=0.
- Read latency: `mem_rd_en` at cycle k, data captured at k+1, `tx_start` at k+2 at the earliest.
- `tx_start` is never high for 2 consecutive cycles and is never asserted while `tx_busy`=1.
- Timeout counter starts at 0 on the `tx_start` cycle. `err` rises on the cycle the count reaches ACK_TIMEOUT.
- `start` while `busy`=1 is ignored; it does not restart or queue a frame.
- All outputs are registered.

## Structure
- Shared package `pe_pkg`: state enum, default HEADER constant, byte-type encoding (HDR/DATA/CSUM).
- One sub-module is natural: `tx_handshake`, which contains TXREQ/TXACK/TXWAIT and the timeout counter. It takes `send` and returns `sent` and `timeout`. The top FSM handles framing and addressing.

## Test plan
- DEPTH=4, memC={01,02,04,08}, UART model with 10-cycle busy → bytes A5,01,02,04,08,0F in order; `checksum`=0F; one `done` pulse; `err`=0.
- `tx_busy` held high when `start` is given → no `tx_start` until `tx_busy` falls; header sent then.
- UART model never raises `tx_busy` → `err`=1 exactly ACK_TIMEOUT cycles after the header `tx_start`; state IDLE; no `done`. A following `start` clears `err`.
- Second `start` pulse in mid-frame → ignored; exactly 6 bytes sent.
- `rst` asserted after the 2nd data byte → all outputs at reset values immediately; no further `tx_start`. A new `start` re-sends the full frame from A5.
- DEPTH=1, memC={FF} → A5,FF,FF; `mem_addr` stays 0 throughout.
